// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART-to-FIFO bridge: TX FSM states,
// default command symbols and the count-width helper.
package uart_fifo_pkg;

    // TX sequencing states of the bridge
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_WAIT  = 3'd4
    } tx_state_t;

    // Default command symbols ('!' starts a dump, '~' clears overflow)
    localparam logic [7:0] DEF_DUMP_CMD = 8'h21;
    localparam logic [7:0] DEF_CLR_CMD  = 8'h7E;

    // Width of an occupancy counter able to hold 0..depth inclusive
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// Synchronous FIFO with registered read data and registered status.
// A write while full is accepted only if a read happens in the same cycle.
module sync_fifo
    import uart_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_rd_ok;
    logic              w_wr_ok;
    logic [CNT_W-1:0]  w_count_nxt;

    assign w_rd_ok = rd_en && !r_empty;
    assign w_wr_ok = wr_en && (!r_full || w_rd_ok);

    // Occupancy after this edge; simultaneous read and write leave it unchanged
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_ok && !w_rd_ok) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_wr_ok && w_rd_ok) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr_ok && !rst) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy, status flags and registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_rd_data <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign rd_data = r_rd_data;
    assign count   = r_count;
    assign full    = r_full;
    assign empty   = r_empty;

endmodule

// File: rtl/uart_fifo_bridge.sv
// UART-to-FIFO bridge: buffers received symbols and returns them to the
// UART transmitter, either as a command-triggered dump (MODE=0) or as a
// continuous echo stream (MODE=1).
module uart_fifo_bridge
    import uart_fifo_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       DEPTH    = 16,
    parameter int unsigned       MODE     = 0,
    parameter logic [DATA_W-1:0] DUMP_CMD = DATA_W'(DEF_DUMP_CMD),
    parameter logic [DATA_W-1:0] CLR_CMD  = DATA_W'(DEF_CLR_CMD),
    localparam int unsigned      CNT_W    = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [CNT_W-1:0]  r_remain;
    logic              r_wait_skip;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_overflow;

    logic              w_is_dump;
    logic              w_is_clr;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_tx_start;
    logic              w_drop;
    logic              w_dump_go;
    logic [DATA_W-1:0] w_fifo_rd_data;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;

    // Command symbols are consumed here and never reach the FIFO
    assign w_is_dump = (MODE == 0) && rx_valid && (rx_data == DUMP_CMD);
    assign w_is_clr  = rx_valid && (rx_data == CLR_CMD);
    assign w_wr_en   = rx_valid && !w_is_dump && !w_is_clr;
    assign w_drop    = w_wr_en && w_full && !w_rd_en;

    // A dump starts only from IDLE and only with something to send
    assign w_dump_go = w_is_dump && (r_state == ST_IDLE) && (w_count != '0);

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_data (rx_data),
        .rd_en   (w_rd_en),
        .rd_data (w_fifo_rd_data),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    // TX FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // TX FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (MODE != 0) begin
                    if (!w_empty) begin
                        w_state_nxt = ST_FETCH;
                    end
                end else if (w_dump_go) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: w_state_nxt = ST_LOAD;
            ST_LOAD:  w_state_nxt = ST_SEND;
            ST_SEND: begin
                if (!tx_busy) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // First WAIT cycle is skipped so tx_busy has time to rise
                if (!r_wait_skip && !tx_busy) begin
                    if (MODE == 0) begin
                        w_state_nxt = (r_remain != '0) ? ST_FETCH : ST_IDLE;
                    end else begin
                        w_state_nxt = (!w_empty) ? ST_FETCH : ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // TX FSM outputs: FIFO read strobe and transmitter start pulse
    always_comb begin
        w_rd_en    = 1'b0;
        w_tx_start = 1'b0;
        case (r_state)
            ST_FETCH: w_rd_en    = 1'b1;
            ST_SEND:  w_tx_start = !tx_busy;
            default: begin
                w_rd_en    = 1'b0;
                w_tx_start = 1'b0;
            end
        endcase
    end

    // Dump length counter, WAIT skip flag and transmit data register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remain    <= '0;
            r_wait_skip <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            r_wait_skip <= (r_state == ST_SEND) && !tx_busy;
            if (w_dump_go) begin
                r_remain <= w_count;
            end else if ((r_state == ST_FETCH) && (MODE == 0)) begin
                r_remain <= r_remain - CNT_W'(1);
            end
            if (r_state == ST_LOAD) begin
                r_tx_data <= w_fifo_rd_data;
            end
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (w_is_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign tx_start = w_tx_start;
    assign tx_data  = r_tx_data;
    assign count    = w_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge: one instance in dump mode,
// one in streaming mode, each with an emulated UART transmitter.
module tb_uart_fifo_bridge;

    localparam int unsigned BUSY_LEN = 20;
    localparam int unsigned DEPTH    = 16;
    localparam logic [7:0]  DUMP     = 8'h21;
    localparam logic [7:0]  CLR      = 8'h7E;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    // Dump-mode instance signals
    logic       rst0 = 1'b1, rx_valid0 = 1'b0, tx_busy0 = 1'b0;
    logic [7:0] rx_data0 = 8'h00;
    logic       tx_start0, full0, empty0, ovf0;
    logic [7:0] tx_data0;
    logic [4:0] count0;

    // Stream-mode instance signals
    logic       rst1 = 1'b1, rx_valid1 = 1'b0, tx_busy1 = 1'b0;
    logic [7:0] rx_data1 = 8'h00;
    logic       tx_start1, full1, empty1, ovf1;
    logic [7:0] tx_data1;
    logic [4:0] count1;

    uart_fifo_bridge #(.DATA_W(8), .DEPTH(DEPTH), .MODE(0), .DUMP_CMD(DUMP), .CLR_CMD(CLR)) dut0 (
        .clk(clk), .rst(rst0), .rx_valid(rx_valid0), .rx_data(rx_data0), .tx_busy(tx_busy0),
        .tx_start(tx_start0), .tx_data(tx_data0), .count(count0), .full(full0),
        .empty(empty0), .overflow(ovf0));

    uart_fifo_bridge #(.DATA_W(8), .DEPTH(DEPTH), .MODE(1), .DUMP_CMD(DUMP), .CLR_CMD(CLR)) dut1 (
        .clk(clk), .rst(rst1), .rx_valid(rx_valid1), .rx_data(rx_data1), .tx_busy(tx_busy1),
        .tx_start(tx_start1), .tx_data(tx_data1), .count(count1), .full(full1),
        .empty(empty1), .overflow(ovf1));

    // Reference model state
    logic [7:0]  mq0[$];           // bytes held by the dump-mode FIFO
    logic [7:0]  exp0[$], got0[$]; // expected / observed transmissions
    logic [7:0]  exp1[$], got1[$];
    int unsigned st1[$];           // cycles of stream-mode tx_start
    logic        m_ovf0 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Transmitter emulation and tx_data stability monitors
    logic [7:0]  hold0, hold1;
    bit          hv0 = 0, hv1 = 0, pend0 = 0, pend1 = 0;
    int unsigned bc0 = 0, bc1 = 0;

    always @(negedge clk) begin
        if (rst0) begin
            hv0 = 0;
        end else begin
            if (tx_busy0 && hv0) chk("tx_data0_stable", tx_data0, hold0);
            if (tx_start0) begin
                chk("tx_start0_not_busy", tx_busy0, 0);
                got0.push_back(tx_data0);
                hold0 = tx_data0; hv0 = 1; pend0 = 1;
            end
        end
        if (!rst1) begin
            if (tx_busy1 && hv1) chk("tx_data1_stable", tx_data1, hold1);
            if (tx_start1) begin
                chk("tx_start1_not_busy", tx_busy1, 0);
                got1.push_back(tx_data1);
                st1.push_back(cyc);
                hold1 = tx_data1; hv1 = 1; pend1 = 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (pend0) begin tx_busy0 = 1'b1; bc0 = BUSY_LEN; pend0 = 0; end
        else if (bc0 > 0) begin bc0--; if (bc0 == 0) begin tx_busy0 = 1'b0; hv0 = 0; end end
        if (pend1) begin tx_busy1 = 1'b1; bc1 = BUSY_LEN; pend1 = 0; end
        else if (bc1 > 0) begin bc1--; if (bc1 == 0) begin tx_busy1 = 1'b0; hv1 = 0; end end
    end

    function automatic logic [7:0] rnd_byte(input bit allow_dump);
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (b == CLR || (!allow_dump && b == DUMP));
        return b;
    endfunction

    // Send one symbol to the dump-mode instance and update the model
    task automatic send0(input logic [7:0] b);
        bit dumping;
        dumping = (exp0.size() != got0.size());
        @(negedge clk); rx_valid0 = 1'b1; rx_data0 = b;
        @(negedge clk); rx_valid0 = 1'b0;
        if (b == CLR) m_ovf0 = 1'b0;
        else if (b == DUMP) begin
            if (!dumping) while (mq0.size() > 0) exp0.push_back(mq0.pop_front());
        end
        else if (mq0.size() < DEPTH) mq0.push_back(b);
        else m_ovf0 = 1'b1;
    endtask

    task automatic send1(input logic [7:0] b);
        @(negedge clk); rx_valid1 = 1'b1; rx_data1 = b;
        @(negedge clk); rx_valid1 = 1'b0;
        if (b != CLR) exp1.push_back(b);
    endtask

    task automatic wait_got0(input int unsigned n, input string tag);
        int unsigned k = 0;
        while (got0.size() < n && k < 2000) begin @(negedge clk); k++; end
        chk({tag, "_wait"}, got0.size() >= n, 1);
    endtask

    task automatic drain0(input string tag);
        int unsigned k = 0;
        while (got0.size() < exp0.size() && k < 3000) begin @(negedge clk); k++; end
        repeat (BUSY_LEN + 10) @(negedge clk);
        chk({tag, "_len"}, got0.size(), exp0.size());
        for (int i = 0; i < exp0.size() && i < got0.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), got0[i], exp0[i]);
        got0.delete(); exp0.delete();
        chk({tag, "_count"}, count0, mq0.size());
        chk({tag, "_ovf"}, ovf0, m_ovf0);
    endtask

    task automatic drain1(input string tag);
        int unsigned k = 0;
        while (got1.size() < exp1.size() && k < 4000) begin @(negedge clk); k++; end
        repeat (BUSY_LEN + 10) @(negedge clk);
        chk({tag, "_len"}, got1.size(), exp1.size());
        for (int i = 0; i < exp1.size() && i < got1.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), got1[i], exp1[i]);
        got1.delete(); exp1.delete();
        chk({tag, "_count"}, count1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0, s0, s1;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst0_tx_start", tx_start0, 0); chk("rst0_tx_data", tx_data0, 0);
        chk("rst0_count", count0, 0);       chk("rst0_full", full0, 0);
        chk("rst0_empty", empty0, 1);       chk("rst0_ovf", ovf0, 0);
        chk("rst1_tx_start", tx_start1, 0); chk("rst1_tx_data", tx_data1, 0);
        chk("rst1_count", count1, 0);       chk("rst1_empty", empty1, 1);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);

        // Basic dump of 'A','B','C'
        send0(8'h41); send0(8'h42); send0(8'h43);
        chk("t1_count3", count0, mq0.size());
        chk("t1_empty", empty0, 0);
        send0(DUMP);
        drain0("t1");

        // Fill to full, overflow, dump, clear
        for (int i = 0; i < 16; i++) send0(8'(i));
        send0(8'h10);
        chk("t2_full", full0, 1);
        chk("t2_count", count0, mq0.size());
        chk("t2_ovf", ovf0, m_ovf0);
        send0(DUMP);
        drain0("t2");
        chk("t2_ovf_sticky", ovf0, 1);
        send0(CLR);
        chk("t2_ovf_clr", ovf0, m_ovf0);
        chk("t2_clr_not_stored", count0, mq0.size());

        // Wrap-around with random data
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) send0(rnd_byte(0));
            chk($sformatf("t3_r%0d_count", r), count0, mq0.size());
            send0(DUMP);
            drain0($sformatf("t3_r%0d", r));
        end

        // Data and a second dump command arriving mid-dump
        for (int i = 0; i < 4; i++) send0(8'hA0 + 8'(i));
        send0(DUMP);
        wait_got0(1, "t4_first");
        send0(8'h55);
        send0(DUMP);
        drain0("t4");
        chk("t4_count1", count0, 1);
        send0(DUMP);
        drain0("t4b");

        // Reset while waiting on the transmitter
        for (int i = 0; i < 6; i++) send0(8'h60 + 8'(i));
        send0(DUMP);
        wait_got0(1, "t6_first");
        repeat (2) @(negedge clk);
        chk("t6_count5", count0, 5);
        rst0 = 1'b1;
        @(negedge clk);
        chk("t6_tx_start", tx_start0, 0);
        chk("t6_tx_data", tx_data0, 0);
        chk("t6_count", count0, 0);
        chk("t6_empty", empty0, 1);
        rst0 = 1'b0;
        chk("t6_first_byte", got0.size() > 0 ? got0[0] : 8'hxx, 8'h60);
        mq0.delete(); exp0.delete(); got0.delete();
        send0(DUMP);
        repeat (40) @(negedge clk);
        chk("t6_no_tx", got0.size(), 0);

        // Streaming latency and busy handshake
        @(negedge clk); t0 = cyc; rx_valid1 = 1'b1; rx_data1 = 8'h31; exp1.push_back(8'h31);
        @(negedge clk); rx_data1 = 8'h32; exp1.push_back(8'h32);
        @(negedge clk); rx_valid1 = 1'b0;
        drain1("t5");
        chk("t5_starts", st1.size(), 2);
        s0 = (st1.size() > 0) ? st1[0] : 0;
        s1 = (st1.size() > 1) ? st1[1] : 0;
        chk("t5_latency", s0 - t0, 4);
        chk("t5_second_after_busy", s1 - s0, BUSY_LEN + 4);
        st1.delete();

        // Random stream echo; clear symbol is not echoed
        for (int i = 0; i < 10; i++) send1(rnd_byte(1));
        send1(CLR);
        drain1("t7");
        st1.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
